muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Multi-cycle RV32M multiply/divide unit for the pipelined core. It sits beside the ALU in the execute stage. The hazard logic holds the pipeline while busy_o is high and kills the operation on a flush. All eight M-extension operations run on a shared iterative datapath, one bit per cycle, with a final sign-fix cycle. Divide-by-zero and signed-overflow cases take a fast path.

Parameters:
DATA_WIDTH, 32, operand/result width; must be even and >= 8
CNT_WIDTH, $clog2(DATA_WIDTH), width of the iteration counter

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous reset, active-high
start_i  input  1  request a new operation; sampled in IDLE or DONE only
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA_i  input  DATA_WIDTH  rs1 operand (multiplicand/dividend)
SrcB_i  input  DATA_WIDTH  rs2 operand (multiplier/divisor)
kill_i  input  1  pipeline flush; aborts any in-flight operation
busy_o  output  1  high in CALC and FIX
done_o  output  1  one-cycle pulse, result valid
Result_o  output  DATA_WIDTH  result; held from done_o until the next accepted start

Behaviour:
- Reset: state = IDLE. busy_o = 0, done_o = 0, Result_o = 0, counter = 0, all internal registers = 0. Reset overrides start_i and kill_i, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE:
  - start_i = 1 and kill_i = 0: latch op_i, operand magnitudes and sign flags, load counter = DATA_WIDTH-1.
  - Go to CALC, or straight to DONE on the fast path.
  - start_i = 0: DONE returns to IDLE after exactly one cycle.
- CALC: one iteration per edge; counter decrements. At counter == 0 the next edge goes to FIX. CALC lasts exactly DATA_WIDTH cycles.
- FIX: apply sign correction (two's-complement negate) and select the low half, high half, quotient or remainder into Result_o. Go to DONE.
- DONE: done_o = 1 for exactly this one cycle.
- Latency: start sampled at edge k gives done_o high in the cycle after edge k+DATA_WIDTH+1, i.e. DATA_WIDTH+2 cycles (34 at default). Fast path: done_o high in the cycle after edge k (1 cycle).
- Signedness:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL: low half; sign-independent.
  - DIV/REM: signed.
- Sign rules:
  - Product sign = sA ^ sB.
  - Quotient sign = sA ^ sB.
  - Remainder sign = sA.
- Multiply: unsigned shift-add on magnitudes into a 2*DATA_WIDTH accumulator.
- Divide: unsigned restoring divide on magnitudes.
- Fast paths (taken at start, no CALC/FIX):
  - Divisor == 0: DIV/DIVU give all-ones; REM/REMU give SrcA_i.
  - Signed overflow (DIV/REM with A = most-negative, B = -1): DIV gives most-negative; REM gives 0.
- start_i while busy_o = 1 is ignored; no queuing, and the operation in flight is undisturbed.
- kill_i = 1 in any state: next state IDLE, no done_o.
  - Result_o keeps its previous value.
  - kill_i and start_i in the same cycle: kill wins, start is not accepted.
- Back-to-back: start_i asserted during DONE is accepted. done_o still pulses that cycle, and the new operation begins the next cycle.
- Operand inputs need not be held stable after the start edge.

Test Plan:
- Reset mid-CALC (10 cycles after MUL start): rst=1 for one edge -> busy_o=0, done_o=0, Result_o=0; no done_o pulse afterwards.
- MUL 7 x -3, then MULH 0x80000000 x 0x80000000 -> 0xFFFFFFEB with done_o 34 cycles after start; then 0x40000000. Also MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each with done_o one cycle after start and busy_o never high.
- kill_i at cycle 20 of a DIVU: returns to IDLE, no done_o, Result_o unchanged. start_i during busy is ignored and the current result is still correct.
- Back-to-back: MUL 3x4 with start_i held high through DONE, followed by DIVU 9/2 -> done_o with 12, then done_o again 34 cycles later with 4.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit: iterative RV32M multiply/divide, one bit per cycle + sign fix |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] SrcA_i,
   input  logic [DATA_WIDTH-1:0] SrcB_i,
   input  logic                  kill_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] Result_o
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0]  CNT_LOAD = CNT_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
   logic [2:0]                op_q, op_d;
   logic [DATA_WIDTH-1:0]     opnd_q, opnd_d;
   logic [2*DATA_WIDTH-1:0]   acc_q, acc_d;
   logic                      neg_q, neg_d;
   logic [DATA_WIDTH-1:0]     result_q, result_d;

   logic                      accept;
   logic                      is_div;
   logic                      a_signed, b_signed;
   logic                      a_neg, b_neg;
   logic [DATA_WIDTH-1:0]     mag_a, mag_b;
   logic                      b_zero, sgn_ovf;
   logic [DATA_WIDTH:0]       mul_sum;
   logic [2*DATA_WIDTH-1:0]   mul_step;
   logic [DATA_WIDTH:0]       div_shift, div_diff;
   logic [2*DATA_WIDTH-1:0]   div_step;
   logic [2*DATA_WIDTH-1:0]   prod;
   logic [DATA_WIDTH-1:0]     quot, rmdr;

   always_comb begin
      accept   = start_i && !kill_i;
      is_div   = op_i[2];
      a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
      b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
      a_neg    = a_signed && SrcA_i[DATA_WIDTH-1];
      b_neg    = b_signed && SrcB_i[DATA_WIDTH-1];
      mag_a    = a_neg ? (~SrcA_i + 1'b1) : SrcA_i;
      mag_b    = b_neg ? (~SrcB_i + 1'b1) : SrcB_i;
      b_zero   = (SrcB_i == '0);
      sgn_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (SrcA_i == MOST_NEG) && (SrcB_i == {DATA_WIDTH{1'b1}});

      // Shift-add: low half of acc holds the remaining multiplier bits.
      mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                 (acc_q[0] ? {1'b0, opnd_q} : {(DATA_WIDTH+1){1'b0}});
      mul_step = {mul_sum, acc_q[DATA_WIDTH-1:1]};

      // Restoring divide: upper half is the partial remainder, lower half the quotient.
      div_shift = {acc_q[2*DATA_WIDTH-1:DATA_WIDTH], acc_q[DATA_WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (!div_diff[DATA_WIDTH]) begin
         div_step = {div_diff[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
         div_step = {div_shift[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b0};
      end

      prod = neg_q ? (~acc_q + 1'b1) : acc_q;
      quot = neg_q ? (~acc_q[DATA_WIDTH-1:0] + 1'b1) : acc_q[DATA_WIDTH-1:0];
      rmdr = neg_q ? (~acc_q[2*DATA_WIDTH-1:DATA_WIDTH] + 1'b1)
                   : acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      result_d = result_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               op_d  = op_i;
               cnt_d = CNT_LOAD;
               if (is_div && b_zero) begin
                  result_d = op_i[1] ? SrcA_i : {DATA_WIDTH{1'b1}};
                  state_d  = DONE;
               end else if (sgn_ovf) begin
                  result_d = op_i[1] ? '0 : MOST_NEG;
                  state_d  = DONE;
               end else begin
                  opnd_d  = is_div ? mag_b : mag_a;
                  acc_d   = {{DATA_WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                  neg_d   = (is_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = op_q[2] ? div_step : mul_step;
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            case (op_q)
               OP_MUL:                        result_d = prod[DATA_WIDTH-1:0];
               OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod[2*DATA_WIDTH-1:DATA_WIDTH];
               OP_DIV, OP_DIVU:               result_d = quot;
               OP_REM, OP_REMU:               result_d = rmdr;
               default:                       result_d = result_q;
            endcase
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      if (kill_i) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign busy_o   = (state_q == CALC) || (state_q == FIX);
   assign done_o   = (state_q == DONE);
   assign Result_o = result_q;

endmodule
`default_nettype wire
